io_ctrl_regs: RTL and testbench
===============================

# io_ctrl_regs

Memory-mapped control/status register block that sits directly upstream and downstream of the multi-port I/O capture stage. It holds every configuration vector the capture stage consumes: enable, noise cancelling, interrupt mask, edge select and interrupt select. It generates one-cycle per-port clear pulses. It returns the capture word to the processor through coherent 64-bit reads, and converts the capture stage's level IRQ into a sticky, acknowledgeable interrupt.

## Interface
- `NUM_PORTS`, 12, number of I/O ports; legal range 1–16, so that 2*NUM_PORTS ≤ 32.
- `DATA_WIDTH`, 64, width of the capture word from the I/O stage; fixed at 64.
- `ID_VALUE`, 32'h494F_0001, constant returned by the ID register.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  bus request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  4  word address.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `io_enable`  out  1  enable to the I/O stage (CTRL[0]).
- `io_clr`  out  NUM_PORTS  per-port capture clear pulses.
- `io_noise_en`  out  NUM_PORTS  per-port noise-cancelling enables.
- `io_irq_mask`  out  NUM_PORTS  per-port interrupt mask.
- `io_select_edge`  out  2*NUM_PORTS  edge select, 2 bits per port.
- `io_select_irq`  out  2*NUM_PORTS  interrupt select, 2 bits per port.
- `io_data`  in  DATA_WIDTH  capture word from the I/O stage.
- `io_irq`  in  1  level IRQ from the I/O stage.
- `irq_out`  out  1  interrupt to the processor.

## Operation
- Register map (word address):
  - 0 CTRL rw: [0] enable, [1] irq_en.
  - 1 NOISE_EN rw.
  - 2 IRQ_MASK rw.
  - 3 EDGE_SEL rw.
  - 4 IRQ_SEL rw.
  - 5 CLR wo: pulse; reads 0.
  - 6 DATA_LO ro.
  - 7 DATA_HI ro.
  - 8 IRQ_STATUS: [0] pending, write 1 to clear.
  - 9 ID ro.
  - 10–15: reads 0, writes ignored.
- Width rules:
  - Writes take `req_wdata[W-1:0]`, where W is the register width; upper bits are ignored.
  - Reads are zero-extended to 32 bits.
  - Writes to read-only registers have no effect.
- FSM has two states: IDLE and RESP. Reset state is IDLE.
  - IDLE: `req_ready`=1. On accept, perform the write (or sample read data) and go to RESP.
  - RESP: `req_ready`=0, `rsp_valid`=1, then return to IDLE unconditionally. There is no response backpressure.
- Coherent 64-bit read:
  - Reading DATA_LO returns `io_data[31:0]` and latches `io_data[63:32]` into a shadow register in the same cycle.
  - Reading DATA_HI returns the shadow, not live data.
  - The shadow resets to 0.
- CLR: an accepted write drives `io_clr` = `wdata[NUM_PORTS-1:0]` for exactly one cycle, then 0. A write of 0 produces no pulse.
- IRQ:
  - The previous `io_irq` value is registered; a 0→1 edge sets `pending`.
  - A W1C write to IRQ_STATUS[0] clears `pending`. If the edge and the clear occur in the same cycle, set wins.
  - `irq_out` = `pending & irq_en`, registered.
  - A level `io_irq` held high does not re-set `pending` after it is cleared.
- Reset:
  - All registers, shadow, pending, `io_*` outputs, `rsp_valid`, `rsp_rdata` and `irq_out` reset to 0.
  - `req_ready` is 1 from the first cycle after release.
  - Assertion mid-transaction aborts it: no response and no write commit if asserted before the accept edge.

## Timing
- Accept edge at cycle T:
  - A write updates its register at T, so the `io_*` output is visible from T+1.
  - Read data and `rsp_valid` are visible during T+1.
- `io_clr` is high only during T+1.
- Maximum throughput is one transaction per 2 cycles.
- Latency from `io_irq` rising (sampled at edge E) to `irq_out` high is 2 cycles: `pending` is set at E+1, `irq_out` at E+2.
- Read data is sampled at the accept edge. Later register changes do not alter `rsp_rdata`.

## Test plan
- Reset, then read ID -> `rsp_rdata`=0x494F0001 one cycle after accept, `req_ready`=0 in that cycle. Verify every `io_*` output is 0 while `rst_n`=0.
- Write EDGE_SEL=0xFFAA_5501 with NUM_PORTS=12 -> `io_select_edge`=24'hAA5501 next cycle; read back 0x00AA5501.
- Write CLR=0x0F3 -> `io_clr`=12'h0F3 for exactly one cycle, then 0; read CLR -> 0.
- With `io_data`=0x1111_2222_3333_4444, read DATA_LO -> 0x33334444. Change `io_data` to 0xAAAA_BBBB_CCCC_DDDD, then read DATA_HI -> 0x11112222.
- Set CTRL=0x3, raise `io_irq` -> `irq_out`=1 two cycles later.
  - Write IRQ_STATUS=1 with `io_irq` held high -> `irq_out` falls and stays 0.
  - Drop and re-raise `io_irq` on the same edge as a W1C -> `pending` stays 1.
- Assert `rst_n`=0 while in RESP -> `rsp_valid` drops immediately; all registers read 0 after release.

Source files
------------

// File: rtl/io_ctrl_regs.sv
// io_ctrl_regs: control/status register block for the multi-port I/O capture stage.
// Holds the capture-stage configuration, generates per-port clear pulses, returns
// the 64-bit capture word through a coherent lo/hi read pair, and turns the level
// IRQ from the capture stage into a sticky, acknowledgeable interrupt.
module io_ctrl_regs #(
    parameter int unsigned NUM_PORTS  = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [31:0] ID_VALUE   = 32'h494F_0001
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [3:0]                req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      io_enable,
    output logic [NUM_PORTS-1:0]      io_clr,
    output logic [NUM_PORTS-1:0]      io_noise_en,
    output logic [NUM_PORTS-1:0]      io_irq_mask,
    output logic [2*NUM_PORTS-1:0]    io_select_edge,
    output logic [2*NUM_PORTS-1:0]    io_select_irq,
    input  logic [DATA_WIDTH-1:0]     io_data,
    input  logic                      io_irq,
    output logic                      irq_out
);

    localparam int unsigned SEL_W = 2 * NUM_PORTS;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_NOISE_EN   = 4'd1;
    localparam logic [3:0] ADDR_IRQ_MASK   = 4'd2;
    localparam logic [3:0] ADDR_EDGE_SEL   = 4'd3;
    localparam logic [3:0] ADDR_IRQ_SEL    = 4'd4;
    localparam logic [3:0] ADDR_CLR        = 4'd5;
    localparam logic [3:0] ADDR_DATA_LO    = 4'd6;
    localparam logic [3:0] ADDR_DATA_HI    = 4'd7;
    localparam logic [3:0] ADDR_IRQ_STATUS = 4'd8;
    localparam logic [3:0] ADDR_ID         = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0]           ctrl_q,    ctrl_d;
    logic [NUM_PORTS-1:0] noise_q,   noise_d;
    logic [NUM_PORTS-1:0] mask_q,    mask_d;
    logic [SEL_W-1:0]     edge_q,    edge_d;
    logic [SEL_W-1:0]     irqsel_q,  irqsel_d;
    logic [NUM_PORTS-1:0] clr_q,     clr_d;
    logic [31:0]          shadow_q,  shadow_d;
    logic [31:0]          rdata_q,   rdata_d;
    logic                 irq_q,     irq_d;
    logic                 irq_prev_q, irq_prev_d;
    logic                 pending_q, pending_d;
    logic                 irq_out_q, irq_out_d;

    logic accept;
    logic pending_clr;
    logic irq_rise;

    // Upper write-data bits beyond the widest register are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^req_wdata;

    assign accept = req_valid & req_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: one response cycle after every accepted request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready only while idle, response valid for the single RESP cycle
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Register writes, read-data capture, shadow latch and interrupt tracking
    always_comb begin
        ctrl_d      = ctrl_q;
        noise_d     = noise_q;
        mask_d      = mask_q;
        edge_d      = edge_q;
        irqsel_d    = irqsel_q;
        clr_d       = '0;
        shadow_d    = shadow_q;
        rdata_d     = '0;
        pending_clr = 1'b0;
        irq_d       = io_irq;
        irq_prev_d  = irq_q;

        if (accept) begin
            if (req_write) begin
                case (req_addr)
                    ADDR_CTRL:       ctrl_d      = req_wdata[1:0];
                    ADDR_NOISE_EN:   noise_d     = req_wdata[NUM_PORTS-1:0];
                    ADDR_IRQ_MASK:   mask_d      = req_wdata[NUM_PORTS-1:0];
                    ADDR_EDGE_SEL:   edge_d      = req_wdata[SEL_W-1:0];
                    ADDR_IRQ_SEL:    irqsel_d    = req_wdata[SEL_W-1:0];
                    ADDR_CLR:        clr_d       = req_wdata[NUM_PORTS-1:0];
                    ADDR_IRQ_STATUS: pending_clr = req_wdata[0];
                    default:         ;
                endcase
            end else begin
                case (req_addr)
                    ADDR_CTRL:       rdata_d = 32'(ctrl_q);
                    ADDR_NOISE_EN:   rdata_d = 32'(noise_q);
                    ADDR_IRQ_MASK:   rdata_d = 32'(mask_q);
                    ADDR_EDGE_SEL:   rdata_d = 32'(edge_q);
                    ADDR_IRQ_SEL:    rdata_d = 32'(irqsel_q);
                    ADDR_DATA_LO: begin
                        rdata_d  = io_data[31:0];
                        shadow_d = io_data[63:32];
                    end
                    ADDR_DATA_HI:    rdata_d = shadow_q;
                    ADDR_IRQ_STATUS: rdata_d = 32'(pending_q);
                    ADDR_ID:         rdata_d = ID_VALUE;
                    default:         rdata_d = '0;
                endcase
            end
        end

        // A fresh rising edge beats a simultaneous acknowledge
        irq_rise  = irq_q & ~irq_prev_q;
        pending_d = irq_rise | (pending_q & ~pending_clr);
        irq_out_d = pending_q & ctrl_q[1];
    end

    // Datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            noise_q    <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            irqsel_q   <= '0;
            clr_q      <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            irq_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            irq_out_q  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            noise_q    <= noise_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            irqsel_q   <= irqsel_d;
            clr_q      <= clr_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            irq_out_q  <= irq_out_d;
        end
    end

    assign rsp_rdata      = rdata_q;
    assign io_enable      = ctrl_q[0];
    assign io_clr         = clr_q;
    assign io_noise_en    = noise_q;
    assign io_irq_mask    = mask_q;
    assign io_select_edge = edge_q;
    assign io_select_irq  = irqsel_q;
    assign irq_out        = irq_out_q;

endmodule

// File: tb/tb_io_ctrl_regs.sv
// tb_io_ctrl_regs: directed, table-driven bench for io_ctrl_regs (NUM_PORTS = 12).
module tb_io_ctrl_regs;

    localparam int unsigned NP = 12;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [3:0]        req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              io_enable;
    logic [NP-1:0]     io_clr;
    logic [NP-1:0]     io_noise_en;
    logic [NP-1:0]     io_irq_mask;
    logic [2*NP-1:0]   io_select_edge;
    logic [2*NP-1:0]   io_select_irq;
    logic [63:0]       io_data;
    logic              io_irq;
    logic              irq_out;

    int checks   = 0;
    int failures = 0;
    logic [NP-1:0] clr_snap;

    io_ctrl_regs #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (64),
        .ID_VALUE   (32'h494F_0001)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .io_enable      (io_enable),
        .io_clr         (io_clr),
        .io_noise_en    (io_noise_en),
        .io_irq_mask    (io_irq_mask),
        .io_select_edge (io_select_edge),
        .io_select_irq  (io_select_irq),
        .io_data        (io_data),
        .io_irq         (io_irq),
        .irq_out        (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus transaction; leaves the caller 1ns after the edge following the response cycle
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
        bit got;
        got   = 1'b0;
        rdata = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            check("ready_timeout", 64'(got), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        check("rsp_valid_high", 64'(rsp_valid), 64'd1);
        check("req_ready_busy", 64'(req_ready), 64'd0);
        rdata    = rsp_rdata;
        clr_snap = io_clr;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        #1;
        check("rsp_valid_pulse_end", 64'(rsp_valid), 64'd0);
    endtask

    task automatic check_io_zero(input string tag);
        check({tag, "_io_enable"}, 64'(io_enable), 64'd0);
        check({tag, "_io_clr"}, 64'(io_clr), 64'd0);
        check({tag, "_io_noise_en"}, 64'(io_noise_en), 64'd0);
        check({tag, "_io_irq_mask"}, 64'(io_irq_mask), 64'd0);
        check({tag, "_io_select_edge"}, 64'(io_select_edge), 64'd0);
        check({tag, "_io_select_irq"}, 64'(io_select_irq), 64'd0);
        check({tag, "_irq_out"}, 64'(irq_out), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;

        vecs.push_back('{1'b0, 4'd9,  32'h0,         32'h494F_0001});
        vecs.push_back('{1'b1, 4'd0,  32'hFFFF_FFFD, 32'h0});
        vecs.push_back('{1'b0, 4'd0,  32'h0,         32'h0000_0001});
        vecs.push_back('{1'b1, 4'd1,  32'hFFFF_F5A5, 32'h0});
        vecs.push_back('{1'b0, 4'd1,  32'h0,         32'h0000_05A5});
        vecs.push_back('{1'b1, 4'd2,  32'h1234_5C3C, 32'h0});
        vecs.push_back('{1'b0, 4'd2,  32'h0,         32'h0000_0C3C});
        vecs.push_back('{1'b1, 4'd3,  32'hFFAA_5501, 32'h0});
        vecs.push_back('{1'b0, 4'd3,  32'h0,         32'h00AA_5501});
        vecs.push_back('{1'b1, 4'd4,  32'h0F0F_0F0F, 32'h0});
        vecs.push_back('{1'b0, 4'd4,  32'h0,         32'h000F_0F0F});
        vecs.push_back('{1'b0, 4'd5,  32'h0,         32'h0});
        vecs.push_back('{1'b1, 4'd9,  32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 4'd9,  32'h0,         32'h494F_0001});
        vecs.push_back('{1'b1, 4'd10, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 4'd10, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 4'd15, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 4'd8,  32'h0,         32'h0});
        vecs.push_back('{1'b0, 4'd7,  32'h0,         32'h0});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        io_data   = 64'h5555_6666_7777_8888;
        io_irq    = 1'b0;
        clr_snap  = '0;

        #1;
        check_io_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 64'(req_ready), 64'd1);

        // Register map round trips, truncation and read-only/unmapped behaviour
        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), 64'(rd), 64'(vecs[i].exp));
        end
        check("io_enable", 64'(io_enable), 64'd1);
        check("io_noise_en", 64'(io_noise_en), 64'h5A5);
        check("io_irq_mask", 64'(io_irq_mask), 64'hC3C);
        check("io_select_edge", 64'(io_select_edge), 64'hAA5501);
        check("io_select_irq", 64'(io_select_irq), 64'h0F0F0F);

        // Clear pulse: one cycle wide, then gone; zero write gives no pulse
        xfer(1'b1, 4'd5, 32'h0000_00F3, rd);
        check("clr_pulse", 64'(clr_snap), 64'h0F3);
        check("clr_after_pulse", 64'(io_clr), 64'h0);
        xfer(1'b1, 4'd5, 32'h0, rd);
        check("clr_zero_write", 64'(clr_snap), 64'h0);
        xfer(1'b0, 4'd5, 32'h0, rd);
        check("clr_read", 64'(rd), 64'h0);

        // Coherent 64-bit read: DATA_HI comes from the shadow captured with DATA_LO
        io_data = 64'h1111_2222_3333_4444;
        xfer(1'b0, 4'd6, 32'h0, rd);
        check("data_lo", 64'(rd), 64'h3333_4444);
        io_data = 64'hAAAA_BBBB_CCCC_DDDD;
        xfer(1'b0, 4'd7, 32'h0, rd);
        check("data_hi_shadow", 64'(rd), 64'h1111_2222);

        // Interrupt: two-cycle latency from the sampling edge
        xfer(1'b1, 4'd0, 32'h3, rd);
        @(negedge clk);
        io_irq = 1'b1;
        @(posedge clk); #1;
        check("irq_out_E", 64'(irq_out), 64'd0);
        @(posedge clk); #1;
        check("irq_out_E1", 64'(irq_out), 64'd0);
        @(posedge clk); #1;
        check("irq_out_E2", 64'(irq_out), 64'd1);
        xfer(1'b0, 4'd8, 32'h0, rd);
        check("status_pending", 64'(rd), 64'd1);

        // Acknowledge with io_irq still high: stays cleared
        xfer(1'b1, 4'd8, 32'h1, rd);
        repeat (4) @(posedge clk);
        #1;
        check("irq_out_after_w1c", 64'(irq_out), 64'd0);
        xfer(1'b0, 4'd8, 32'h0, rd);
        check("status_after_w1c", 64'(rd), 64'd0);

        // Edge and acknowledge on the same edge: the edge wins
        @(negedge clk);
        io_irq = 1'b0;
        repeat (3) @(negedge clk);
        io_irq = 1'b1;
        @(negedge clk);
        check("ready_for_w1c", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd8;
        req_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk); #1;
        check("irq_out_set_wins", 64'(irq_out), 64'd1);
        xfer(1'b0, 4'd8, 32'h0, rd);
        check("status_set_wins", 64'(rd), 64'd1);

        // Reset during the response cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd1;
        @(posedge clk); #1;
        check("resp_before_reset", 64'(rsp_valid), 64'd1);
        rst_n     = 1'b0;
        io_irq    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        #1;
        check_io_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 9; a++) begin
            if (a == 6) continue;
            xfer(1'b0, 4'(a), 32'h0, rd);
            check($sformatf("post_reset_addr%0d", a), 64'(rd), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
